// File: rtl/inst_buffer.sv
// inst_buffer: dual-issue fetch-to-decode instruction queue with branch pre-decode and delay-slot pairing.
// Ports: clk/rst (sync, active-high), flush clears contents; in_valid/in_pc/in_inst push up to two
// instructions when in_ready; out_valid/out_pc*/out_inst*/out_br present the two head entries;
// pop consumes one or two head entries; count is the current occupancy.
// Optional macro IBUF_BYPASS_EN: while empty, incoming instructions are presented on out_* in the same cycle.
module inst_buffer #(
  parameter int AW   = 3,
  parameter int IN_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IN_W-1:0]   in_valid,
  input  logic [31:0]       in_pc,
  input  logic [32*IN_W-1:0] in_inst,
  output logic              in_ready,
  output logic [1:0]        out_valid,
  output logic [31:0]       out_pc0,
  output logic [31:0]       out_pc1,
  output logic [31:0]       out_inst0,
  output logic [31:0]       out_inst1,
  output logic [1:0]        out_br,
  input  logic [1:0]        pop,
  output logic [AW:0]       count
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  if (IN_W != 2) begin : g_bad_in_w
    $error("inst_buffer: IN_W must be 2");
  end
  if (AW < 2) begin : g_bad_aw
    $error("inst_buffer: AW must be at least 2");
  end

  // Branches and jumps with delay slots; branch-likely opcodes are deliberately excluded.
  function automatic logic pre_br(input logic [31:0] i);
    return (i[31:26] >= 6'd1 && i[31:26] <= 6'd7) || (i[31:26] == 6'd0 && i[5:1] == 5'd4);
  endfunction

  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] br_q;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, h1, t1;
  logic [AW:0]      cnt_q, cnt_d, avail;
  logic [1:0]       n_in, n_push, n_pop, pop_eff;
  logic [31:0]      pc0, pc1, inst0, inst1;
  logic             b0, b1;

  assign h1       = head_q + 1'b1;
  assign t1       = tail_q + 1'b1;
  assign in_ready = cnt_q <= (AW+1)'(DEPTH - 2);
  assign n_in     = {&in_valid, in_valid[0] & ~in_valid[1]};
  assign n_push   = in_ready ? n_in : 2'd0;

`ifdef IBUF_BYPASS_EN
  logic byp;
  assign byp   = cnt_q == '0 && in_valid != '0;
  assign avail = byp ? (AW+1)'(n_in) : cnt_q;
  assign pc0   = byp ? in_pc : pc_q[head_q];
  assign pc1   = byp ? in_pc + 32'd4 : pc_q[h1];
  assign inst0 = byp ? in_inst[31:0] : inst_q[head_q];
  assign inst1 = byp ? in_inst[63:32] : inst_q[h1];
  assign b0    = byp ? pre_br(in_inst[31:0]) : br_q[head_q];
  assign b1    = byp ? pre_br(in_inst[63:32]) : br_q[h1];
`else
  assign avail = cnt_q;
  assign pc0   = pc_q[head_q];
  assign pc1   = pc_q[h1];
  assign inst0 = inst_q[head_q];
  assign inst1 = inst_q[h1];
  assign b0    = br_q[head_q];
  assign b1    = br_q[h1];
`endif

  // A branch only issues together with its delay slot; a branch in slot 1 waits to become slot 0.
  assign out_valid[0] = avail >= ONE && !(b0 && avail < TWO);
  assign out_valid[1] = avail >= TWO && out_valid[0] && !b1;
  assign out_br       = {avail >= TWO && b1, avail >= ONE && b0};
  assign out_pc0      = pc0;
  assign out_pc1      = pc1;
  assign out_inst0    = inst0;
  assign out_inst1    = inst1;
  assign count        = cnt_q;

  // Pop bits beyond out_valid are dropped; 10 therefore consumes nothing.
  assign pop_eff = pop & out_valid;
  assign n_pop   = {&pop_eff, pop_eff[0] & ~pop_eff[1]};
  assign head_d  = head_q + AW'(n_pop);
  assign tail_d  = tail_q + AW'(n_push);
  assign cnt_d   = cnt_q + (AW+1)'(n_push) - (AW+1)'(n_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypassed entries are still written; advancing head past them makes them invisible.
  always_ff @(posedge clk) begin
    if (!rst && !flush && n_push != 2'd0) begin
      pc_q[tail_q]   <= in_pc;
      inst_q[tail_q] <= in_inst[31:0];
      br_q[tail_q]   <= pre_br(in_inst[31:0]);
    end
    if (!rst && !flush && n_push == 2'd2) begin
      pc_q[t1]   <= in_pc + 32'd4;
      inst_q[t1] <= in_inst[63:32];
      br_q[t1]   <= pre_br(in_inst[63:32]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) assert ((pop & ~out_valid) == 2'b00);
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed vector table plus randomized traffic checked against a queue model.
module tb_inst_buffer;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0;
  logic [1:0]  in_valid = 2'b00, pop = 2'b00, out_valid, out_br;
  logic [31:0] in_pc = '0, out_pc0, out_pc1, out_inst0, out_inst1;
  logic [63:0] in_inst = '0;
  logic        in_ready;
  logic [AW:0] count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          br;
  } ent_t;
  ent_t q[$];
  bit   m_ok = 0;

  logic [1:0]  s_ov, s_br;
  logic [AW:0] s_cnt;
  logic        s_rdy;
  logic [31:0] s_pc0, s_pc1;

  typedef struct {
    bit          r, f;
    logic [1:0]  iv;
    logic [31:0] pc;
    logic [63:0] ins;
    logic [1:0]  p;
    bit          c;
    logic [1:0]  ov, br;
    logic [AW:0] cnt;
    bit          rdy;
  } vec_t;
  vec_t tv[$];

  inst_buffer #(.AW(AW), .IN_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_br(out_br), .pop(pop), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endfunction

  function automatic bit is_br(logic [31:0] i);
    int op = int'(i[31:26]);
    int fn = int'(i[5:0]);
    return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  function automatic void exp_out(output logic [1:0] ov, output logic [1:0] br);
    int n = q.size();
    bit b0 = n >= 1 && q[0].br;
    bit b1 = n >= 2 && q[1].br;
    ov[0] = n >= 1 && !(b0 && n < 2);
    ov[1] = n >= 2 && ov[0] && !b1;
    br = {b1, b0};
  endfunction

  task automatic step(input bit r, input bit f, input logic [1:0] iv, input logic [31:0] pc,
                      input logic [63:0] ins, input logic [1:0] p);
    logic [1:0] eov, ebr;
    int np, n0;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = ins; pop = p;
    #4;
    s_ov = out_valid; s_br = out_br; s_cnt = count; s_rdy = in_ready; s_pc0 = out_pc0; s_pc1 = out_pc1;
    exp_out(eov, ebr);
    if (m_ok) begin
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_ready", 64'(in_ready), 64'(q.size() <= DEPTH - 2));
      chk("m_valid", 64'(out_valid), 64'(eov));
      chk("m_br", 64'(out_br), 64'(ebr));
      if (eov[0]) begin
        chk("m_pc0", 64'(out_pc0), 64'(q[0].pc));
        chk("m_inst0", 64'(out_inst0), 64'(q[0].inst));
      end
      if (eov[1]) begin
        chk("m_pc1", 64'(out_pc1), 64'(q[1].pc));
        chk("m_inst1", 64'(out_inst1), 64'(q[1].inst));
      end
    end
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      n0 = q.size();
      np = (p[0] && eov[0]) ? ((p[1] && eov[1]) ? 2 : 1) : 0;
      repeat (np) void'(q.pop_front());
      if (n0 <= DEPTH - 2) begin
        if (iv[0]) q.push_back('{pc, ins[31:0], is_br(ins[31:0])});
        if (iv[0] && iv[1]) q.push_back('{pc + 32'd4, ins[63:32], is_br(ins[63:32])});
      end
    end
    if (r) m_ok = 1;
    #1;
  endtask

  localparam logic [63:0] BEQP = {32'h11090003, 32'h24080001};
  localparam logic [63:0] JRP  = {32'h00000000, 32'h03E00008};

  initial begin
    logic [1:0]  eov, ebr, p, iv;
    logic [31:0] ins0, ins1, epc;
    tv.push_back('{1, 0, 2'b00, 32'h0, 64'h0, 2'b00, 0, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b11, 32'hBFC00000, BEQP, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b01, 1, 2'b01, 2'b10, 4'd2, 1});
    tv.push_back('{0, 0, 2'b01, 32'hBFC00008, 64'h0, 2'b00, 1, 2'b00, 2'b01, 4'd1, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b11, 1, 2'b11, 2'b01, 4'd2, 1});
    tv.push_back('{0, 0, 2'b11, 32'h100, JRP, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b11, 1, 2'b11, 2'b01, 4'd2, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b11, 32'h200, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b11, 32'h208, 64'h0, 2'b00, 1, 2'b11, 2'b00, 4'd2, 1});
    tv.push_back('{0, 0, 2'b11, 32'h210, 64'h0, 2'b00, 1, 2'b11, 2'b00, 4'd4, 1});
    tv.push_back('{0, 0, 2'b11, 32'h218, 64'h0, 2'b00, 1, 2'b11, 2'b00, 4'd6, 1});
    tv.push_back('{0, 0, 2'b11, 32'h220, 64'h0, 2'b00, 1, 2'b11, 2'b00, 4'd8, 0});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b11, 1, 2'b11, 2'b00, 4'd8, 0});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b01, 1, 2'b11, 2'b00, 4'd6, 1});
    tv.push_back('{0, 1, 2'b11, 32'h300, 64'h0, 2'b01, 1, 2'b11, 2'b00, 4'd5, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b11, 32'h400, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{1, 0, 2'b11, 32'h408, 64'h0, 2'b00, 1, 2'b11, 2'b00, 4'd2, 1});
    tv.push_back('{1, 0, 2'b00, 32'h0, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});
    tv.push_back('{0, 0, 2'b00, 32'h0, 64'h0, 2'b00, 1, 2'b00, 2'b00, 4'd0, 1});

    @(posedge clk);
    #1;
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].f, tv[i].iv, tv[i].pc, tv[i].ins, tv[i].p);
      if (tv[i].c) begin
        chk($sformatf("v%0d_valid", i), 64'(s_ov), 64'(tv[i].ov));
        chk($sformatf("v%0d_br", i), 64'(s_br), 64'(tv[i].br));
        chk($sformatf("v%0d_count", i), 64'(s_cnt), 64'(tv[i].cnt));
        chk($sformatf("v%0d_ready", i), 64'(s_rdy), 64'(tv[i].rdy));
      end
      if (i == 4) chk("slot_pc1", 64'(s_pc1), 64'h0BFC00008);
    end

    epc = 32'h1000;
    step(0, 0, 2'b11, 32'h1000, 64'h0, 2'b00);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 2'b11, 32'h1008 + 32'(8 * k), 64'h0, 2'b11);
      chk("wrap_pc0", 64'(s_pc0), 64'(epc));
      chk("wrap_pc1", 64'(s_pc1), 64'(epc + 32'd4));
      chk("wrap_count", 64'(s_cnt), 64'd2);
      epc = epc + 32'd8;
    end
    step(0, 1, 2'b00, 32'h0, 64'h0, 2'b00);

    for (int k = 0; k < 400; k++) begin
      exp_out(eov, ebr);
      case ($urandom_range(0, 2))
        0: iv = 2'b00;
        1: iv = 2'b01;
        default: iv = 2'b11;
      endcase
      ins0 = $urandom;
      ins1 = $urandom;
      ins0[31:26] = 6'($urandom_range(0, 12));
      ins1[31:26] = 6'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) ins0[5:0] = 6'($urandom_range(8, 9));
      if ($urandom_range(0, 3) == 0) ins1[5:0] = 6'($urandom_range(8, 9));
      p = 2'b00;
      if (eov == 2'b11) p = ($urandom_range(0, 2) == 0) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00);
      else if (eov == 2'b01) p = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
      step(0, $urandom_range(0, 39) == 0, iv, $urandom & 32'hFFFFFFFC, {ins1, ins0}, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
